// File: rtl/enc_mac_seq.sv
// Sequential multiply-accumulate: one lane per cycle, weights re-encoded as floor((w+1)/2)
// into sign/magnitude, products summed into a wrapping accumulator with a sticky overflow flag.
module enc_mac_seq #(
  parameter int unsigned LANES = 4,
  parameter int unsigned ACC_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [4*LANES-1:0]   w_i,
  input  logic [8*LANES-1:0]   a_i,
  input  logic                 clear_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [ACC_W-1:0]     acc_o,
  output logic                 ovf_o,
  output logic                 busy_o
);

  localparam int unsigned LaneW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [4*LANES-1:0] w_q, w_d;
  logic [8*LANES-1:0] a_q, a_d;
  logic [LaneW-1:0]   lane_q, lane_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;

  logic [3:0]         w_sel;
  logic [7:0]         a_sel;
  logic signed [4:0]  w_inc, e_val;
  logic               e_sign;
  logic [2:0]         e_mag;
  logic [7:0]         a_mag;
  logic [9:0]         mag_prod;
  logic [10:0]        prod;
  logic [ACC_W-1:0]   prod_ext, sum;
  logic               ovf_add;

  always_comb begin
    w_sel = '0;
    a_sel = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_q == LaneW'(i)) begin
        w_sel = w_q[4*i +: 4];
        a_sel = a_q[8*i +: 8];
      end
    end
  end

  // Arithmetic shift floors, so -1 lands on +0 and -8 on -4.
  always_comb begin
    w_inc    = $signed({w_sel[3], w_sel}) + 5'sd1;
    e_val    = w_inc >>> 1;
    e_sign   = e_val[4];
    e_mag    = e_sign ? 3'(-e_val) : 3'(e_val);
    a_mag    = a_sel[7] ? 8'(-a_sel) : a_sel;
    mag_prod = 10'(e_mag) * 10'(a_mag);
    prod     = (e_sign ^ a_sel[7]) ? 11'(-{1'b0, mag_prod}) : {1'b0, mag_prod};
    prod_ext = {{(ACC_W-11){prod[10]}}, prod};
    sum      = acc_q + prod_ext;
    ovf_add  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    a_d     = a_q;
    lane_d  = lane_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          w_d     = w_i;
          a_d     = a_i;
          lane_d  = '0;
          state_d = StRun;
          if (clear_i) begin
            acc_d = '0;
            ovf_d = 1'b0;
          end
        end
      end
      StRun: begin
        acc_d = sum;
        ovf_d = ovf_q | ovf_add;
        if (lane_q == LaneW'(LANES - 1)) begin
          state_d = StDone;
        end else begin
          lane_d = LaneW'(lane_q + 1'b1);
        end
      end
      StDone: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      w_q     <= '0;
      a_q     <= '0;
      lane_q  <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      a_q     <= a_d;
      lane_q  <= lane_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign out_valid_o = (state_q == StDone);
  assign acc_o       = acc_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_enc_mac_seq.sv
// Directed bench for enc_mac_seq (LANES=4, ACC_W=16) with hand-computed expectations.
module tb_enc_mac_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] w;
  logic [31:0] a;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] acc;
  logic        ovf;
  logic        busy;

  int checks = 0;
  int errs   = 0;

  enc_mac_seq #(.LANES(4), .ACC_W(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .w_i         (w),
    .a_i         (a),
    .clear_i     (clear),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .acc_o       (acc),
    .ovf_o       (ovf),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand set; returns after the accept edge.
  task automatic start_op(input logic [15:0] wv, input logic [31:0] av, input logic cl);
    chk("in_ready_before_accept", 32'(in_ready), 1);
    in_valid = 1'b1;
    w        = wv;
    a        = av;
    clear    = cl;
    step();
    in_valid = 1'b0;
    w        = 16'h0000;
    a        = 32'h0;
    clear    = 1'b0;
  endtask

  task automatic wait_done();
    int cyc = 0;
    while (!out_valid && cyc < 20) begin
      step();
      cyc++;
    end
    chk("latency", cyc, 4);
  endtask

  task automatic finish_op(input string tag, input logic signed [15:0] exp_acc,
                           input logic exp_ovf);
    chk({tag, "_acc"}, $signed(acc), exp_acc);
    chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_ready_after"}, 32'(in_ready), 1);
  endtask

  task automatic do_op(input string tag, input logic [15:0] wv, input logic [31:0] av,
                       input logic cl, input logic signed [15:0] exp_acc, input logic exp_ovf);
    start_op(wv, av, cl);
    wait_done();
    finish_op(tag, exp_acc, exp_ovf);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; w = '0; a = '0; clear = 1'b0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_acc", $signed(acc), 0);
    chk("rst_ovf", 32'(ovf), 0);

    do_op("basic", 16'h7777, 32'h7F7F7F7F, 1'b1, 16'sd2032, 1'b0);
    do_op("mixed_pos", 16'hFE12, 32'h32323232, 1'b1, 16'sd50, 1'b0);
    do_op("mixed_neg", 16'hFE12, 32'hCECECECE, 1'b1, -16'sd50, 1'b0);

    do_op("acc_first", 16'h7777, 32'h7F7F7F7F, 1'b1, 16'sd2032, 1'b0);
    do_op("acc_second", 16'h7777, 32'h7F7F7F7F, 1'b0, 16'sd4064, 1'b0);
    do_op("neg_weights", 16'h8888, 32'h80808080, 1'b1, 16'sd2048, 1'b0);

    // 16 x 2048 wraps exactly to -32768 on the final addition.
    for (int k = 1; k <= 16; k++) begin
      do_op("ovf_run", 16'h8888, 32'h80808080, (k == 1), 16'(2048 * k), (k == 16));
    end
    do_op("ovf_clear", 16'h7777, 32'h7F7F7F7F, 1'b1, 16'sd2032, 1'b0);

    // Backpressure: hold DONE, and try to inject a new op that must be ignored.
    start_op(16'h7777, 32'h7F7F7F7F, 1'b1);
    wait_done();
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; w = 16'h8888; a = 32'h80808080; clear = 1'b1;
      step();
      chk("bp_acc_stable", $signed(acc), 2032);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_out_valid", 32'(out_valid), 1);
    end
    in_valid = 1'b0; w = '0; a = '0; clear = 1'b0;
    finish_op("bp", 16'sd2032, 1'b0);

    // Reset while lane 2 is the pending lane; accept must also lose to reset.
    start_op(16'h7777, 32'h7F7F7F7F, 1'b1);
    step();
    step();
    chk("mid_run_acc", $signed(acc), 1016);
    chk("mid_run_busy", 32'(busy), 1);
    rst = 1'b1; in_valid = 1'b1; w = 16'h7777; a = 32'h7F7F7F7F;
    step();
    rst = 1'b0; in_valid = 1'b0; w = '0; a = '0;
    chk("rst_run_in_ready", 32'(in_ready), 1);
    chk("rst_run_acc", $signed(acc), 0);
    chk("rst_run_out_valid", 32'(out_valid), 0);
    chk("rst_run_busy", 32'(busy), 0);

    do_op("post_rst", 16'h7777, 32'h7F7F7F7F, 1'b0, 16'sd2032, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
